// File: rtl/dual_output_checker_pkg.sv
// Shared types and helpers for the clocked output checker.
package chk_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} chk_state_t;

   localparam int CNT_W_MIN = 1;
   localparam int CNT_W_MAX = 32;

   function automatic bit cnt_w_ok(input int w);
      return (w >= CNT_W_MIN) && (w <= CNT_W_MAX);
   endfunction

   // All-ones value of a w-bit counter, the saturation ceiling.
   function automatic logic [31:0] sat_max(input int w);
      if (w >= 32) return 32'hFFFF_FFFF;
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/dual_output_checker_if.sv
// Bus bundle between the bench top (master) and the checker (slave).
interface dual_output_checker_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             start;
   logic [WIDTH-1:0] o_ref;
   logic [WIDTH-1:0] o_dut;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] first_err_idx;
   logic [WIDTH-1:0] first_err_ref;
   logic [WIDTH-1:0] first_err_dut;

   modport master (
      output start, o_ref, o_dut,
      input  busy, done, pass, err_count, first_err_idx, first_err_ref, first_err_dut
   );

   modport slave (
      input  start, o_ref, o_dut,
      output busy, done, pass, err_count, first_err_idx, first_err_ref, first_err_dut
   );
endinterface

// File: rtl/dual_output_checker_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter
   import chk_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);
   localparam logic [W-1:0] MAX = W'(sat_max(W));

   logic [W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clr)
         q_d = '0;
      else if (inc && (q_q != MAX))
         q_d = q_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q = q_q;
endmodule

// File: rtl/dual_output_checker.sv
// Clocked 4-state bus comparator over a fixed sample window with first-mismatch capture.
// Optional CHECK_STOP_ON_ERR_EN ends the run on the first mismatch.
module dual_output_checker
   import chk_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SAMPLES = 20000,
   parameter int SETTLE  = 1,
   parameter int CNT_W   = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   dual_output_checker_if.slave bus
);
   localparam int SMP_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
   localparam int STL_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLES - 1);
   localparam logic [STL_W-1:0] STL_LAST = STL_W'((SETTLE > 0) ? SETTLE - 1 : 0);

   if (!cnt_w_ok(CNT_W) || (SAMPLES < 1) || (SETTLE < 0)) begin : g_param_err
      $error("dual_output_checker: illegal CNT_W/SAMPLES/SETTLE");
   end

   chk_state_t       state_q, state_d;
   logic [WIDTH-1:0] ref_q, dut_q;
   logic [SMP_W-1:0] smp_q, smp_d;
   logic [STL_W-1:0] stl_q, stl_d;
   logic             seen_q, seen_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] fref_q, fref_d, fdut_q, fdut_d;
   logic             busy_q, done_q, pass_q;
   logic             clr, inc, mm;
   logic [CNT_W-1:0] err_cnt;

   // Case inequality so X/Z positions must agree exactly.
   assign mm = (ref_q !== dut_q);

   always_comb begin
      state_d = state_q;
      smp_d   = smp_q;
      stl_d   = stl_q;
      seen_d  = seen_q;
      idx_d   = idx_q;
      fref_d  = fref_q;
      fdut_d  = fdut_q;
      clr     = 1'b0;
      inc     = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               clr     = 1'b1;
               smp_d   = '0;
               stl_d   = '0;
               seen_d  = 1'b0;
               idx_d   = '0;
               fref_d  = '0;
               fdut_d  = '0;
               state_d = (SETTLE > 0) ? chk_pkg::SETTLE : RUN;
            end
         end
         chk_pkg::SETTLE: begin
            if (stl_q == STL_LAST) begin
               stl_d   = '0;
               state_d = RUN;
            end else begin
               stl_d = stl_q + STL_W'(1);
            end
         end
         RUN: begin
            if (mm) begin
               inc = 1'b1;
               if (!seen_q) begin
                  seen_d = 1'b1;
                  idx_d  = CNT_W'(smp_q);
                  fref_d = ref_q;
                  fdut_d = dut_q;
               end
            end
            if (smp_q == SMP_LAST) state_d = DONE;
            else                   smp_d   = smp_q + SMP_W'(1);
`ifdef CHECK_STOP_ON_ERR_EN
            if (mm) state_d = DONE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ref_q   <= '0;
         dut_q   <= '0;
         smp_q   <= '0;
         stl_q   <= '0;
         seen_q  <= 1'b0;
         idx_q   <= '0;
         fref_q  <= '0;
         fdut_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ref_q   <= bus.o_ref;
         dut_q   <= bus.o_dut;
         smp_q   <= smp_d;
         stl_q   <= stl_d;
         seen_q  <= seen_d;
         idx_q   <= idx_d;
         fref_q  <= fref_d;
         fdut_q  <= fdut_d;
         // Flags follow the next state so they line up with the final err_count.
         busy_q  <= (state_d == chk_pkg::SETTLE) || (state_d == RUN);
         done_q  <= (state_d == DONE);
         pass_q  <= (state_d == DONE) && !seen_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inc),
      .q     (err_cnt)
   );

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.pass          = pass_q;
   assign bus.err_count     = err_cnt;
   assign bus.first_err_idx = idx_q;
   assign bus.first_err_ref = fref_q;
   assign bus.first_err_dut = fdut_q;
endmodule
